dso_key_ctrl: RTL
=================

DSO_KEY_CTRL -- requirements
Module: dso_key_ctrl

Interface
REQ-001 SHALL have parameters: CLK_FS, default 26'd50_000_000, sys_clk frequency in Hz; TRIG_STEP, default 8'd8, trigger-level step per press; TRIG_Y_BOT, default 12'd400, pixel row for trig_level 0.
REQ-002 SHALL have ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst_n  in  1  reset, synchronous, active-low.
- key_n  in  4  raw buttons, active-low, asynchronous: [3] RUN, [2] MODE, [1] UP, [0] DOWN.
- trig_level  out  8  trigger level, 0-255.
- deci_rate  out  10  decimation rate.
- wave_run  out  1  RUN/STOP.
- trig_edge  out  1  1 = rising, 0 = falling.
- v_scale  out  5  bit4 = 1 zoom-in, 0 zoom-out; [3:0] = factor.
- fft_en  out  1  FFT display enable.
- fir_en  out  1  FIR filter enable.
- trig_line  out  12  pixel row of the trigger marker.
- sel_item  out  3  index of the edited item, for OSD highlight.

Function
REQ-003 SHALL pass each key_n bit through a 2-flop synchronizer, then a debounce counter of CLK_FS/50 cycles (20 ms); the debounced state SHALL change only after the input has been stable for that full count.
REQ-004 SHALL generate a one-cycle press event on each debounced 1->0 transition; releases SHALL generate nothing.
REQ-005 When press events coincide in one cycle, SHALL act on the highest-priority event only (RUN > MODE > UP > DOWN) and drop the rest.
REQ-006 RUN press SHALL toggle wave_run, regardless of sel_item.
REQ-007 sel_item SHALL be a state machine: TRIG(0) -> EDGE(1) -> DECI(2) -> VSCALE(3) -> FFT(4) -> FIR(5) -> TRIG, advancing on each MODE press; values 6-7 are unreachable and SHALL recover to TRIG.
REQ-008 TRIG: UP adds TRIG_STEP and DOWN subtracts it, saturating at 255 / 0 (no wrap).
REQ-009 DECI: UP/DOWN SHALL step through the table 1, 2, 5, 10, 20, 50, 100, 200, 500, 1000, saturating at both ends.
REQ-010 VSCALE: UP/DOWN SHALL step through {0,4}, {0,2}, {1,1}, {1,2}, {1,4} (/4, /2, x1, x2, x4), saturating at both ends.
REQ-011 EDGE, FFT, FIR: UP or DOWN SHALL toggle trig_edge, fft_en or fir_en respectively.
REQ-012 Every output register SHALL update on the cycle after its press event; trig_line SHALL equal TRIG_Y_BOT - trig_level, registered, lagging trig_level by one cycle.
REQ-013 An UP or DOWN event on an item other than the selected one SHALL leave that item unchanged.

Reset
REQ-014 While sys_rst_n = 0 at a sys_clk edge, outputs SHALL be: trig_level 127, deci_rate 1, wave_run 1, trig_edge 1, v_scale {1,1}, fft_en 0, fir_en 0, sel_item 0, trig_line TRIG_Y_BOT-127.
REQ-015 Reset SHALL clear synchronizers, debounce counters, debounced state (released), and repeat timers; a key held through reset SHALL produce no event until released and pressed again.

Configuration
REQ-016 With KEY_AUTOREPEAT_EN defined: a lone UP or DOWN held for CLK_FS/2 cycles SHALL generate a repeat event, then another every CLK_FS/10 cycles until release; UP and DOWN held together SHALL generate no repeats.
REQ-016a Repeats apply only to TRIG, DECI and VSCALE; toggle items SHALL never repeat.
REQ-017 Without KEY_AUTOREPEAT_EN: exactly one event per press, and no repeat timer logic synthesized.

Structure
REQ-018 Shared package dso_pkg SHALL hold: sel_item encodings, deci-rate table, v_scale table, key index constants.
REQ-019 Debounce SHALL be one sub-module, key_debounce (sync + counter + press pulse), instantiated four times.

Verification (CLK_FS = 1000: debounce 20 cycles, hold 500, repeat 100)
REQ-020 After reset: outputs equal REQ-014 values; 3 UP presses in TRIG -> trig_level 151, trig_line 249 one cycle later.
REQ-021 Bounce: key_n[1] toggling every 5 cycles for 60 cycles, then held low -> exactly one event; trig_level 127 -> 135.
REQ-022 Saturation: select DECI; 12 UP presses -> deci_rate 1000; 12 DOWN presses -> 1; VSCALE 6 DOWN -> {0,4}.
REQ-023 Simultaneous RUN+UP press in TRIG -> wave_run 0, trig_level unchanged 127; 7 MODE presses -> sel_item 1.
REQ-024 KEY_AUTOREPEAT_EN: UP held for 820 cycles after debounce in TRIG -> 1+3 events, trig_level 159; without the macro -> 135.
REQ-025 Reset asserted while UP is held mid-repeat -> REQ-014 values, and no event until UP is released and pressed again.

Source files
------------

// File: rtl/dso_key_ctrl_pkg.sv
// Shared definitions for the DSO front-panel key controller: item encodings,
// key indices, and the decimation / vertical-scale step tables.
package dso_pkg;

    typedef enum logic [2:0] {
        SEL_TRIG   = 3'd0,
        SEL_EDGE   = 3'd1,
        SEL_DECI   = 3'd2,
        SEL_VSCALE = 3'd3,
        SEL_FFT    = 3'd4,
        SEL_FIR    = 3'd5
    } sel_e;

    localparam int KEY_DOWN = 0;
    localparam int KEY_UP   = 1;
    localparam int KEY_MODE = 2;
    localparam int KEY_RUN  = 3;

    localparam logic [3:0] DECI_MAX       = 4'd9;
    localparam logic [2:0] VSCALE_MAX     = 3'd4;
    localparam logic [2:0] VSCALE_RST_IDX = 3'd2;

    // 1-2-5 sequence from 1 to 1000
    function automatic logic [9:0] deci_of(input logic [3:0] idx);
        case (idx)
            4'd0:    deci_of = 10'd1;
            4'd1:    deci_of = 10'd2;
            4'd2:    deci_of = 10'd5;
            4'd3:    deci_of = 10'd10;
            4'd4:    deci_of = 10'd20;
            4'd5:    deci_of = 10'd50;
            4'd6:    deci_of = 10'd100;
            4'd7:    deci_of = 10'd200;
            4'd8:    deci_of = 10'd500;
            default: deci_of = 10'd1000;
        endcase
    endfunction

    // {zoom_in, factor}: /4, /2, x1, x2, x4
    function automatic logic [4:0] vscale_of(input logic [2:0] idx);
        case (idx)
            3'd0:    vscale_of = {1'b0, 4'd4};
            3'd1:    vscale_of = {1'b0, 4'd2};
            3'd2:    vscale_of = {1'b1, 4'd1};
            3'd3:    vscale_of = {1'b1, 4'd2};
            default: vscale_of = {1'b1, 4'd4};
        endcase
    endfunction

endpackage

// File: rtl/dso_key_ctrl_debounce.sv
// One key: 2-flop synchronizer, down-counting debounce timer, press pulse.
// A key seen low coming out of reset must be released before it can press.
module key_debounce #(
    parameter int unsigned CNT = 20
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_n,
    output logic press,
    output logic level
);

    localparam int unsigned CW = $clog2(CNT + 1);

    logic [1:0]    sync;
    logic          stable;
    logic          armed;
    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync   <= 2'b00;
            stable <= 1'b1;
            armed  <= 1'b0;
            cnt    <= CW'(CNT - 1);
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= CW'(CNT - 1);
                if (stable) armed <= 1'b1;
            end else if (cnt == '0) begin
                stable <= sync[1];
                cnt    <= CW'(CNT - 1);
                press  <= armed & ~sync[1];
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign level = armed & ~stable;

endmodule

// File: rtl/dso_key_ctrl.sv
// DSO front-panel key controller; define KEY_AUTOREPEAT_EN for UP/DOWN
// auto-repeat on the stepped items (TRIG, DECI, VSCALE).
//
// state      | meaning
// SEL_TRIG   | UP/DOWN step trig_level by TRIG_STEP, saturating
// SEL_EDGE   | UP/DOWN toggle trig_edge
// SEL_DECI   | UP/DOWN walk the decimation table
// SEL_VSCALE | UP/DOWN walk the vertical-scale table
// SEL_FFT    | UP/DOWN toggle fft_en
// SEL_FIR    | UP/DOWN toggle fir_en
module dso_key_ctrl
    import dso_pkg::*;
#(
    parameter logic [25:0] CLK_FS     = 26'd50_000_000,
    parameter logic [7:0]  TRIG_STEP  = 8'd8,
    parameter logic [11:0] TRIG_Y_BOT = 12'd400
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  key_n,
    output logic [7:0]  trig_level,
    output logic [9:0]  deci_rate,
    output logic        wave_run,
    output logic        trig_edge,
    output logic [4:0]  v_scale,
    output logic        fft_en,
    output logic        fir_en,
    output logic [11:0] trig_line,
    output logic [2:0]  sel_item
);

    localparam int unsigned DB_CNT = int'(CLK_FS) / 50;

    logic [3:0] press;
    logic [3:0] held;
    logic       rpt_up;
    logic       rpt_down;
    logic       unused_held;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(.CNT(DB_CNT)) u_key (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .key_n     (key_n[i]),
            .press     (press[i]),
            .level     (held[i])
        );
    end

    sel_e       sel;
    logic [3:0] deci_idx;
    logic [2:0] vs_idx;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned HOLD = int'(CLK_FS) / 2;
    localparam int unsigned RATE = int'(CLK_FS) / 10;
    localparam int unsigned RW   = $clog2(HOLD + 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_ok;
    logic          rpt_hit;

    // Only a lone UP or DOWN on a stepped item repeats; anything else rearms
    assign rpt_ok  = (held[KEY_UP] ^ held[KEY_DOWN]) &&
                     (sel == SEL_TRIG || sel == SEL_DECI || sel == SEL_VSCALE);
    assign rpt_hit = rpt_ok && (rpt_cnt == '0);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || !rpt_ok) rpt_cnt <= RW'(HOLD);
        else if (rpt_cnt == '0)    rpt_cnt <= RW'(RATE - 1);
        else                       rpt_cnt <= rpt_cnt - 1'b1;
    end

    assign rpt_up      = rpt_hit & held[KEY_UP];
    assign rpt_down    = rpt_hit & held[KEY_DOWN];
    assign unused_held = ^held[3:2];
`else
    assign rpt_up      = 1'b0;
    assign rpt_down    = 1'b0;
    assign unused_held = ^held;
`endif

    logic ev_run, ev_mode, ev_up, ev_down;
    assign ev_run  = press[KEY_RUN];
    assign ev_mode = press[KEY_MODE];
    assign ev_up   = press[KEY_UP] | rpt_up;
    assign ev_down = press[KEY_DOWN] | rpt_down;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sel        <= SEL_TRIG;
            trig_level <= 8'd127;
            deci_idx   <= 4'd0;
            vs_idx     <= VSCALE_RST_IDX;
            deci_rate  <= deci_of(4'd0);
            v_scale    <= vscale_of(VSCALE_RST_IDX);
            wave_run   <= 1'b1;
            trig_edge  <= 1'b1;
            fft_en     <= 1'b0;
            fir_en     <= 1'b0;
            trig_line  <= TRIG_Y_BOT - 12'd127;
        end else begin
            trig_line <= TRIG_Y_BOT - {4'd0, trig_level};
            if (ev_run) begin
                wave_run <= ~wave_run;
            end else if (ev_mode) begin
                case (sel)
                    SEL_TRIG:   sel <= SEL_EDGE;
                    SEL_EDGE:   sel <= SEL_DECI;
                    SEL_DECI:   sel <= SEL_VSCALE;
                    SEL_VSCALE: sel <= SEL_FFT;
                    SEL_FFT:    sel <= SEL_FIR;
                    default:    sel <= SEL_TRIG;
                endcase
            end else if (ev_up || ev_down) begin
                case (sel)
                    SEL_TRIG: begin
                        if (ev_up)
                            trig_level <= (trig_level > 8'd255 - TRIG_STEP) ? 8'd255
                                                                            : trig_level + TRIG_STEP;
                        else
                            trig_level <= (trig_level < TRIG_STEP) ? 8'd0
                                                                   : trig_level - TRIG_STEP;
                    end
                    SEL_EDGE: trig_edge <= ~trig_edge;
                    SEL_DECI: begin
                        if (ev_up && deci_idx != DECI_MAX) begin
                            deci_idx  <= deci_idx + 4'd1;
                            deci_rate <= deci_of(deci_idx + 4'd1);
                        end else if (!ev_up && deci_idx != 4'd0) begin
                            deci_idx  <= deci_idx - 4'd1;
                            deci_rate <= deci_of(deci_idx - 4'd1);
                        end
                    end
                    SEL_VSCALE: begin
                        if (ev_up && vs_idx != VSCALE_MAX) begin
                            vs_idx  <= vs_idx + 3'd1;
                            v_scale <= vscale_of(vs_idx + 3'd1);
                        end else if (!ev_up && vs_idx != 3'd0) begin
                            vs_idx  <= vs_idx - 3'd1;
                            v_scale <= vscale_of(vs_idx - 3'd1);
                        end
                    end
                    SEL_FFT: fft_en <= ~fft_en;
                    SEL_FIR: fir_en <= ~fir_en;
                    default: sel    <= SEL_TRIG;
                endcase
            end
        end
    end

    assign sel_item = sel;

endmodule
